// File: rtl/mem_req_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_req_arb_pkg;

  localparam int MEM_TAG_NUM = 15;
  localparam int MEM_TAG_W   = 4;
  localparam int ADDR_W      = 64;
  localparam int DATA_W      = 64;

  // Highest legal tag value, sized to the tag bus for clean compares.
  localparam logic [MEM_TAG_W-1:0] TAG_MAX = MEM_TAG_W'(MEM_TAG_NUM);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } mem_cmd_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_req_arb_if.sv
// Bundle of requester, memory and completion signals around the arbiter.
// slave: the arbiter's view. master: the surrounding caches and memory.
interface mem_req_arb_if;
  import mem_req_arb_pkg::*;

  logic                 ic_req_i;
  logic [ADDR_W-1:0]    ic_addr_i;
  logic                 ic_ack_o;
  logic [MEM_TAG_W-1:0] ic_tag_o;
  logic                 ic_rsp_vld_o;

  logic                 dc_req_i;
  mem_cmd_t             dc_cmd_i;
  logic [ADDR_W-1:0]    dc_addr_i;
  logic [DATA_W-1:0]    dc_data_i;
  logic                 dc_ack_o;
  logic [MEM_TAG_W-1:0] dc_tag_o;
  logic                 dc_rsp_vld_o;

  logic [DATA_W-1:0]    rsp_data_o;
  logic [MEM_TAG_W-1:0] rsp_tag_o;

  mem_cmd_t             mem_cmd_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [DATA_W-1:0]    mem_data_o;
  logic [MEM_TAG_W-1:0] mem_response_i;
  logic [MEM_TAG_W-1:0] mem_tag_i;
  logic [DATA_W-1:0]    mem_data_i;

  logic                 arb_busy_o;

  modport slave (
    input  ic_req_i, ic_addr_i,
    output ic_ack_o, ic_tag_o, ic_rsp_vld_o,
    input  dc_req_i, dc_cmd_i, dc_addr_i, dc_data_i,
    output dc_ack_o, dc_tag_o, dc_rsp_vld_o,
    output rsp_data_o, rsp_tag_o,
    output mem_cmd_o, mem_addr_o, mem_data_o,
    input  mem_response_i, mem_tag_i, mem_data_i,
    output arb_busy_o
  );

  modport master (
    output ic_req_i, ic_addr_i,
    input  ic_ack_o, ic_tag_o, ic_rsp_vld_o,
    output dc_req_i, dc_cmd_i, dc_addr_i, dc_data_i,
    input  dc_ack_o, dc_tag_o, dc_rsp_vld_o,
    input  rsp_data_o, rsp_tag_o,
    input  mem_cmd_o, mem_addr_o, mem_data_o,
    output mem_response_i, mem_tag_i, mem_data_i,
    input  arb_busy_o
  );

endinterface

// File: rtl/mem_tag_owner_tbl.sv
// Per-tag owner table: which requester is waiting on each outstanding load tag.
// Entry 0 is never allocated since tag 0 means "no tag" on the memory bus.
module mem_tag_owner_tbl
  import mem_req_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  arb_owner_e           alloc_owner,
  input  logic                 clr_en,
  input  logic [MEM_TAG_W-1:0] clr_tag,
  input  logic [MEM_TAG_W-1:0] lkp_tag,
  output logic                 lkp_hit,
  output arb_owner_e           lkp_owner,
  output logic                 busy
);

  logic [MEM_TAG_NUM:0] valid_q, valid_d;
  logic [MEM_TAG_NUM:0] own_dc_q, own_dc_d;

  // Next-state: clear first so a same-tag allocation in the same cycle wins.
  always_comb begin
    valid_d  = valid_q;
    own_dc_d = own_dc_q;
    if (clr_en) valid_d[clr_tag] = 1'b0;
    if (alloc_en) begin
      valid_d[alloc_tag]  = 1'b1;
      own_dc_d[alloc_tag] = (alloc_owner == OWN_DC);
    end
  end

  // Table registers; reset drops every outstanding entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      own_dc_q <= '0;
    end else begin
      valid_q  <= valid_d;
      own_dc_q <= own_dc_d;
    end
  end

  // Lookup is combinational so the completion is routed in its own cycle.
  always_comb begin
    lkp_hit   = (lkp_tag != '0) && (lkp_tag <= TAG_MAX) && valid_q[lkp_tag];
    lkp_owner = own_dc_q[lkp_tag] ? OWN_DC : OWN_IC;
    busy      = |valid_q;
  end

endmodule

// File: rtl/mem_req_arb.sv
// Round-robin arbiter between the I-cache fetch path and the D-cache MSHR
// issue path onto the single memory command port, with completion routing.
module mem_req_arb
  import mem_req_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_req_arb_if.slave  bus
);

  arb_owner_e prio_q, prio_d;
  logic       ic_win, dc_win, accept;
  mem_cmd_t   cmd;
  logic       lkp_hit;
  arb_owner_e lkp_owner;
  logic       busy;

  // Grant, command mux and priority update; a rejected grant keeps priority.
  always_comb begin
    ic_win = bus.ic_req_i && (!bus.dc_req_i || (prio_q == OWN_IC));
    dc_win = bus.dc_req_i && !ic_win;
    cmd    = ic_win ? BUS_LOAD : (dc_win ? bus.dc_cmd_i : BUS_NONE);
    accept = (ic_win || dc_win) && (bus.mem_response_i != '0);
    prio_d = prio_q;
    if (accept && ic_win && bus.dc_req_i) prio_d = OWN_DC;
    if (accept && dc_win && bus.ic_req_i) prio_d = OWN_IC;
  end

  // Round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) prio_q <= OWN_IC;
    else     prio_q <= prio_d;
  end

  mem_tag_owner_tbl u_tbl (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (accept && (cmd == BUS_LOAD)),
    .alloc_tag   (bus.mem_response_i),
    .alloc_owner (ic_win ? OWN_IC : OWN_DC),
    .clr_en      (lkp_hit),
    .clr_tag     (bus.mem_tag_i),
    .lkp_tag     (bus.mem_tag_i),
    .lkp_hit     (lkp_hit),
    .lkp_owner   (lkp_owner),
    .busy        (busy)
  );

  assign bus.mem_cmd_o    = cmd;
  assign bus.mem_addr_o   = ic_win ? bus.ic_addr_i : (dc_win ? bus.dc_addr_i : '0);
  assign bus.mem_data_o   = dc_win ? bus.dc_data_i : '0;
  assign bus.ic_ack_o     = ic_win && accept;
  assign bus.dc_ack_o     = dc_win && accept;
  assign bus.ic_tag_o     = (ic_win && accept) ? bus.mem_response_i : '0;
  assign bus.dc_tag_o     = (dc_win && accept) ? bus.mem_response_i : '0;
  assign bus.ic_rsp_vld_o = lkp_hit && (lkp_owner == OWN_IC);
  assign bus.dc_rsp_vld_o = lkp_hit && (lkp_owner == OWN_DC);
  assign bus.rsp_data_o   = lkp_hit ? bus.mem_data_i : '0;
  assign bus.rsp_tag_o    = lkp_hit ? bus.mem_tag_i : '0;
  assign bus.arb_busy_o   = busy;

  // Memory must never hand out tags beyond the table.
  a_resp_tag_legal: assert property (@(posedge clk) disable iff (rst)
    (bus.mem_response_i <= TAG_MAX));
  a_cpl_tag_legal: assert property (@(posedge clk) disable iff (rst)
    (bus.mem_tag_i <= TAG_MAX));

endmodule

// File: tb/tb_mem_req_arb.sv
// Bench for mem_req_arb: directed scenarios then randomized traffic against a
// tag-map reference model.
module tb_mem_req_arb;
  import mem_req_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_req_arb_if bus();

  mem_req_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: who has priority, and a map tag -> owner ("I" / "D").
  bit         m_ic_prio;
  string      m_owner [int];
  int         last_win; // 0 none, 1 IC, 2 DC

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic idle_inputs();
    bus.ic_req_i       = 1'b0;
    bus.ic_addr_i      = '0;
    bus.dc_req_i       = 1'b0;
    bus.dc_cmd_i       = BUS_NONE;
    bus.dc_addr_i      = '0;
    bus.dc_data_i      = '0;
    bus.mem_response_i = '0;
    bus.mem_tag_i      = '0;
    bus.mem_data_i     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    m_owner.delete();
    m_ic_prio = 1'b1;
  endtask

  // One cycle: drive at negedge, check combinational outputs, then advance the
  // model across the rising edge.
  task automatic step(input bit icr, input bit dcr, input mem_cmd_t dcmd,
                      input logic [63:0] iaddr, input logic [63:0] daddr,
                      input logic [63:0] ddata, input logic [3:0] resp,
                      input logic [3:0] ctag, input logic [63:0] cdata);
    int       win;
    mem_cmd_t ecmd;
    bit       acc, hit;
    string    who;
    @(negedge clk);
    bus.ic_req_i       = icr;
    bus.ic_addr_i      = iaddr;
    bus.dc_req_i       = dcr;
    bus.dc_cmd_i       = dcmd;
    bus.dc_addr_i      = daddr;
    bus.dc_data_i      = ddata;
    bus.mem_response_i = resp;
    bus.mem_tag_i      = ctag;
    bus.mem_data_i     = cdata;
    #1;
    if (icr && dcr) win = m_ic_prio ? 1 : 2;
    else if (icr)   win = 1;
    else if (dcr)   win = 2;
    else            win = 0;
    last_win = win;
    ecmd = (win == 1) ? BUS_LOAD : ((win == 2) ? dcmd : BUS_NONE);
    acc  = (win != 0) && (resp != 0);
    hit  = (ctag != 0) && m_owner.exists(int'(ctag));
    who  = hit ? m_owner[int'(ctag)] : "";

    check("mem_cmd", 64'(bus.mem_cmd_o), 64'(ecmd));
    if (win == 0) begin
      check("mem_addr_idle", bus.mem_addr_o, 64'd0);
      check("mem_data_idle", bus.mem_data_o, 64'd0);
    end else if (win == 1) begin
      check("mem_addr_ic", bus.mem_addr_o, iaddr);
    end else begin
      check("mem_addr_dc", bus.mem_addr_o, daddr);
      check("mem_data_dc", bus.mem_data_o, ddata);
    end
    check("ic_ack", 64'(bus.ic_ack_o), 64'(acc && win == 1));
    check("dc_ack", 64'(bus.dc_ack_o), 64'(acc && win == 2));
    if (acc && win == 1) check("ic_tag", 64'(bus.ic_tag_o), 64'(resp));
    if (acc && win == 2) check("dc_tag", 64'(bus.dc_tag_o), 64'(resp));
    check("ic_rsp_vld", 64'(bus.ic_rsp_vld_o), 64'(hit && who == "I"));
    check("dc_rsp_vld", 64'(bus.dc_rsp_vld_o), 64'(hit && who == "D"));
    if (hit) begin
      check("rsp_data", bus.rsp_data_o, cdata);
      check("rsp_tag", 64'(bus.rsp_tag_o), 64'(ctag));
    end
    check("arb_busy", 64'(bus.arb_busy_o), 64'(m_owner.num() != 0));

    @(posedge clk);
    if (hit) m_owner.delete(int'(ctag));
    if (acc && ecmd == BUS_LOAD) m_owner[int'(resp)] = (win == 1) ? "I" : "D";
    if (acc && win == 1 && dcr) m_ic_prio = 1'b0;
    if (acc && win == 2 && icr) m_ic_prio = 1'b1;
  endtask

  task automatic idle_step(input logic [3:0] ctag, input logic [63:0] cdata);
    step(0, 0, BUS_NONE, 0, 0, 0, 4'd0, ctag, cdata);
  endtask

  initial begin
    idle_inputs();
    m_ic_prio = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Reset state with no requests.
    #1;
    check("rst_busy", 64'(bus.arb_busy_o), 64'd0);
    check("rst_cmd", 64'(bus.mem_cmd_o), 64'(BUS_NONE));
    check("rst_ic_ack", 64'(bus.ic_ack_o), 64'd0);
    check("rst_dc_ack", 64'(bus.dc_ack_o), 64'd0);

    // 1: single DC load, tag 3, completion 0xDEAD.
    step(0, 1, BUS_LOAD, 0, 64'h100, 0, 4'd3, 4'd0, 0);
    idle_step(4'd0, 0);
    check("t1_busy_set", 64'(bus.arb_busy_o), 64'd1);
    idle_step(4'd3, 64'hDEAD);
    idle_step(4'd0, 0);
    check("t1_busy_clr", 64'(bus.arb_busy_o), 64'd0);

    // 2: both requesting, tags 1..4 -> IC, DC, IC, DC.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, BUS_LOAD, 64'h1000 + 64'(i), 64'h2000 + 64'(i), 0, 4'(i), 4'd0, 0);
      check("t2_winner", 64'(last_win), (i % 2 == 1) ? 64'd1 : 64'd2);
    end
    for (int i = 1; i <= 4; i++) idle_step(4'(i), 64'(i * 16));

    // 3: both requesting, three rejects then accept on tag 5.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, BUS_LOAD, 64'h3000, 64'h4000, 0, (i == 3) ? 4'd5 : 4'd0, 4'd0, 0);
      check("t3_winner", 64'(last_win), 64'd1);
    end
    step(1, 1, BUS_LOAD, 64'h3000, 64'h4000, 0, 4'd0, 4'd0, 0);
    check("t3_next_dc", 64'(last_win), 64'd2);

    // 4: DC store on tag 7, completion produces nothing.
    do_reset();
    step(0, 1, BUS_STORE, 0, 64'h500, 64'hCAFE, 4'd7, 4'd0, 0);
    idle_step(4'd7, 64'h1234);
    idle_step(4'd0, 0);

    // 5: IC on tag 2, DC on tag 9, completions 9 then 2.
    do_reset();
    step(1, 0, BUS_LOAD, 64'h600, 0, 0, 4'd2, 4'd0, 0);
    step(0, 1, BUS_LOAD, 0, 64'h700, 0, 4'd9, 4'd0, 0);
    idle_step(4'd9, 64'h99);
    idle_step(4'd2, 64'h22);
    idle_step(4'd0, 0);

    // 6: reset with tag 4 outstanding, then stale completion.
    do_reset();
    step(1, 0, BUS_LOAD, 64'h800, 0, 0, 4'd4, 4'd0, 0);
    do_reset();
    idle_step(4'd4, 64'h44);
    idle_step(4'd0, 0);

    // Randomized traffic respecting "a tag is only reissued after completion".
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int free_tags [$];
      int busy_tags [$];
      logic [3:0] resp, ctag;
      mem_cmd_t dcmd;
      for (int t = 1; t <= MEM_TAG_NUM; t++) begin
        if (m_owner.exists(t)) busy_tags.push_back(t);
        else                   free_tags.push_back(t);
      end
      resp = 4'd0;
      if (free_tags.size() != 0 && $urandom_range(3) != 0)
        resp = 4'(free_tags[$urandom_range(free_tags.size() - 1)]);
      ctag = 4'd0;
      case ($urandom_range(3))
        0, 1: if (busy_tags.size() != 0)
                ctag = 4'(busy_tags[$urandom_range(busy_tags.size() - 1)]);
        2:    ctag = 4'($urandom_range(MEM_TAG_NUM));
        default: ctag = 4'd0;
      endcase
      dcmd = ($urandom_range(1) != 0) ? BUS_LOAD : BUS_STORE;
      step(1'($urandom_range(1)), 1'($urandom_range(1)), dcmd,
           {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           resp, ctag, {$urandom, $urandom});
      if (n % 150 == 149) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_req_arb.md
Name: mem_req_arb

Overview:
- Shares the single memory command port between the I-cache fetch path and the D-cache MSHR issue path (loads, store misses, dirty evictions).
- Each cycle, picks one requester with round-robin priority and drives the memory command.
- Records which requester owns each memory transaction tag that is still waiting for data.
- When memory returns a tag, sends the returned data-valid to the owning requester.

Parameters:
- MEM_TAG_NUM, 15, number of usable non-zero memory tags (1..MEM_TAG_NUM).
- MEM_TAG_W, 4, width of the memory tag bus.
- ADDR_W, 64, address width.
- DATA_W, 64, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ic_req_i  in  1  I-cache load request valid
- ic_addr_i  in  ADDR_W  I-cache block address
- ic_ack_o  out  1  I-cache request accepted by memory this cycle
- ic_tag_o  out  MEM_TAG_W  tag assigned to the accepted I-cache request
- ic_rsp_vld_o  out  1  data for an I-cache tag is on rsp_data_o
- dc_req_i  in  1  D-cache request valid (MSHR issue enable)
- dc_cmd_i  in  mem_cmd_t  BUS_LOAD or BUS_STORE
- dc_addr_i  in  ADDR_W  D-cache address
- dc_data_i  in  DATA_W  store or evict data
- dc_ack_o  out  1  D-cache request accepted this cycle (drives the MSHR ack)
- dc_tag_o  out  MEM_TAG_W  tag assigned to the accepted D-cache load
- dc_rsp_vld_o  out  1  data for a D-cache tag is on rsp_data_o
- rsp_data_o  out  DATA_W  returned memory data, shared by both requesters
- rsp_tag_o  out  MEM_TAG_W  returned tag, passed through
- mem_cmd_o  out  mem_cmd_t  BUS_NONE, BUS_LOAD or BUS_STORE
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory store data
- mem_response_i  in  MEM_TAG_W  same-cycle accept tag; 0 means rejected
- mem_tag_i  in  MEM_TAG_W  completion tag; 0 means no completion
- mem_data_i  in  DATA_W  completion data
- arb_busy_o  out  1  at least one owner-table entry is valid

Behaviour:
- Reset: prio_r = IC; owner table cleared (all valid = 0). With no requests, every output is 0 / BUS_NONE.
- Grant is combinational:
  - Only one requester asserting: that requester wins.
  - Both asserting: the prio_r side wins.
  - Winner's command, address and data go to mem_*_o. An I-cache win is always BUS_LOAD. No requester: BUS_NONE.
- Accept: mem_response_i != 0 in the same cycle as the winner's command.
  - Winner's ack_o = 1 and its tag_o = mem_response_i. The loser's ack_o = 0.
  - If the accepted command is BUS_LOAD, set owner table entry [mem_response_i] to {valid = 1, owner = winner} on the next edge.
  - BUS_STORE never allocates an entry.
- Reject: mem_response_i == 0. No ack, no allocation, prio_r unchanged, so the same winner keeps priority and retries.
- Priority update: on an accepted grant, prio_r moves to the other requester, but only if the other requester asserted a request that cycle. Otherwise prio_r is unchanged.
- Completion: when mem_tag_i != 0 and entry [mem_tag_i] is valid:
  - Assert ic_rsp_vld_o or dc_rsp_vld_o according to the entry's owner, in the same cycle.
  - rsp_data_o = mem_data_i and rsp_tag_o = mem_tag_i.
  - Clear the entry on the next edge.
- A completion for an invalid entry (for example a store completion) produces no rsp_vld and no state change.
- Same-cycle allocate and clear of the same tag: the allocation wins. Memory only reissues a tag after completing it.
- Store-to-memory enforces no ordering. The MSHR queue order is relied on.
- arb_busy_o = OR of all entry valid bits (registered state).
- Reset mid-operation: every entry is dropped and later completions for old tags are ignored. Upstream requesters are reset in the same cycle.
- Tag values above MEM_TAG_NUM are illegal. An assertion fires on them.

Decomposition:
- Shared package holds:
  - mem_cmd_t {BUS_NONE, BUS_LOAD, BUS_STORE}
  - arb_owner_e {OWN_IC, OWN_DC}
  - MEM_TAG_W and MEM_TAG_NUM constants
- Sub-module mem_tag_owner_tbl: the owner table with its alloc port, clear port and lookup port.
- mem_req_arb contains the grant/priority logic and the datapath muxing.

Test Plan:
1. Reset, then dc_req_i = 1 with BUS_LOAD to address 0x100 and mem_response_i = 3 → dc_ack_o = 1 and dc_tag_o = 3. Next cycle arb_busy_o = 1. Then mem_tag_i = 3 with data 0xDEAD → dc_rsp_vld_o = 1, rsp_data_o = 0xDEAD, and arb_busy_o = 0 the following cycle.
2. Both requesting every cycle, memory accepting with tags 1, 2, 3, 4 → grants go IC, DC, IC, DC, and only the winner sees an ack each cycle.
3. Both requesting, mem_response_i = 0 for 3 cycles, then 5 → IC stays granted throughout; its ack arrives on the 4th cycle with tag 5; next winner is DC.
4. DC BUS_STORE accepted with tag 7, then mem_tag_i = 7 → dc_ack_o = 1 at accept; no rsp_vld on completion; arb_busy_o stays 0.
5. IC load on tag 2 and DC load on tag 9 outstanding; completions arrive 9 then 2 → dc_rsp_vld_o, then ic_rsp_vld_o, with matching rsp_tag_o.
6. rst asserted while tag 4 is outstanding, then mem_tag_i = 4 → no rsp_vld on either side; arb_busy_o = 0.
